// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: generates raster timing, fetches one framebuffer word per
// visible pixel and drives RGB333 plus syncs, aligned through a two-tick pipeline.
module vga_fb_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        fb_ready,
    output logic        fb_re,
    output logic [19:0] fb_addr,
    input  logic [8:0]  fb_data,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [2:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned AW      = 20;
    localparam int unsigned PW      = 9;

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_nxt;
    logic            h_last, v_last, wrap;
    logic            visible, hs_act, vs_act, rd;
    logic            rd_q, tick_q;
    logic [PW-1:0]   pix_reg;
    logic            vis_d1, hs_d1, vs_d1;

    assign h_last  = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last  = (v_cnt == VW'(V_TOTAL - 1));
    assign wrap    = pix_en && h_last && v_last;
    assign visible = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_act  = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act  = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

    // Read strobe coincides with the pixel tick so data is back before the next tick.
    assign rd          = pix_en && visible && (state_q == S_RUN);
    assign addr_nxt    = (h_cnt == '0 && v_cnt == '0) ? '0 : addr_q + AW'(1);
    assign fb_re       = rd;
    assign fb_addr     = rd ? addr_nxt : addr_q;
    assign frame_start = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter RUN only on a frame boundary so the first fetch lands at address 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (wrap && fb_ready) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (rd) begin
            addr_q <= addr_nxt;
        end
    end

    // Capture slot follows every tick; ticks without a read load black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            tick_q  <= 1'b0;
            pix_reg <= '0;
        end else begin
            rd_q   <= rd;
            tick_q <= pix_en;
            if (tick_q) begin
                pix_reg <= rd_q ? fb_data : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis_d1    <= 1'b0;
            hs_d1     <= ~SYNC_POL;
            vs_d1     <= ~SYNC_POL;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else if (pix_en) begin
            vis_d1    <= visible;
            hs_d1     <= hs_act ? SYNC_POL : ~SYNC_POL;
            vs_d1     <= vs_act ? SYNC_POL : ~SYNC_POL;
            vga_hsync <= hs_d1;
            vga_vsync <= vs_d1;
            vga_r     <= vis_d1 ? pix_reg[8:6] : 3'd0;
            vga_g     <= vis_d1 ? pix_reg[5:3] : 3'd0;
            vga_b     <= vis_d1 ? pix_reg[2:0] : 3'd0;
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a shrunken raster (15x8 ticks per frame),
// checking every tick against position-derived expectations plus per-scenario totals.
module tb_vga_fb_scanout;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int LT = HA + HFP + HS + HBP;
    localparam int FT = LT * (VA + VFP + VS + VBP);
    localparam int LAST_ADDR = HA * VA - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        fb_ready = 1'b0;
    logic        fb_re;
    logic [19:0] fb_addr;
    logic [8:0]  fb_data = '0;
    logic [2:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_start;

    always #5 clk = ~clk;

    vga_fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .fb_ready(fb_ready),
        .fb_re(fb_re), .fb_addr(fb_addr), .fb_data(fb_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    function automatic logic [8:0] mem_word(input logic [19:0] a);
        return a[8:0] ^ 9'h1E0;
    endfunction

    // One-cycle-latency RAM model
    always @(posedge clk) begin
        if (fb_re) fb_data <= mem_word(fb_addr);
    end

    typedef struct {
        string name;
        int    gap;
        int    ticks;
        int    rdy_on;
        int    rdy_off;
        int    exp_reads;
        int    exp_fs;
        int    exp_hs;
        int    exp_vs;
        int    exp_last;
    } vec_t;

    int checks = 0;
    int passed = 0;

    int n, last_addr, prev_addr, prev_p;
    bit running, prev_rd;
    int c_reads, c_fs, c_hs, c_vs;
    int e_rd, e_fs, e_sync, e_rgb, e_hold;
    logic [8:0] last_px;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic start_vec();
        pix_en = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n = 0; running = 0; last_addr = 0; prev_rd = 0; prev_addr = 0; prev_p = -1;
        c_reads = 0; c_fs = 0; c_hs = 0; c_vs = 0;
        e_rd = 0; e_fs = 0; e_sync = 0; e_rgb = 0; e_hold = 0;
        last_px = 'x;
    endtask

    task automatic run_ticks(input int gap, input int cnt, input int on, input int off);
        for (int k = 0; k < cnt; k++) begin
            int p, h, v, ph, pv, g;
            bit vis, exp_re, exp_hs, exp_vs;
            logic [8:0]  exp_rgb;
            logic [10:0] snap;
            logic [19:0] snap_addr;
            p = n % FT; h = p % LT; v = p / LT;
            vis = (h < HA) && (v < VA);
            @(negedge clk);
            fb_ready = (n >= on) && (n < off);
            pix_en = 1'b1;
            #1;
            exp_re = running && vis;
            if (fb_re !== exp_re) e_rd++;
            if (exp_re && fb_addr !== 20'(v * HA + h)) e_rd++;
            if (!exp_re && fb_addr !== 20'(last_addr)) e_rd++;
            if (frame_start !== (p == FT - 1)) e_fs++;
            if (fb_re === 1'b1) c_reads++;
            if (frame_start === 1'b1) c_fs++;
            @(negedge clk);
            pix_en = 1'b0;
            #1;
            if (prev_p < 0) begin
                exp_hs = 1; exp_vs = 1; exp_rgb = '0;
            end else begin
                ph = prev_p % LT; pv = prev_p / LT;
                exp_hs = !(ph >= HA + HFP && ph < HA + HFP + HS);
                exp_vs = !(pv >= VA + VFP && pv < VA + VFP + VS);
                exp_rgb = prev_rd ? mem_word(20'(prev_addr)) : 9'd0;
            end
            if (vga_hsync !== exp_hs || vga_vsync !== exp_vs) e_sync++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb) e_rgb++;
            if (vga_hsync === 1'b0) c_hs++;
            if (vga_vsync === 1'b0) c_vs++;
            if (prev_rd && prev_addr == LAST_ADDR) last_px = {vga_r, vga_g, vga_b};
            if (exp_re) last_addr = v * HA + h;
            prev_rd = exp_re; prev_addr = v * HA + h; prev_p = p;
            if (!running && p == FT - 1 && fb_ready) running = 1;
            n++;
            // Between ticks nothing registered may move and no pulses may fire
            g = (gap == 0) ? int'($urandom_range(4, 2)) : gap;
            snap = {vga_r, vga_g, vga_b, vga_hsync, vga_vsync};
            snap_addr = fb_addr;
            for (int j = 0; j < g - 2; j++) begin
                @(negedge clk);
                #1;
                if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync} !== snap || fb_addr !== snap_addr
                    || fb_re !== 1'b0 || frame_start !== 1'b0) e_hold++;
            end
        end
    endtask

    task automatic finish_vec(input vec_t t);
        chk({t.name, "/fb_re_addr_errs"}, e_rd, 0);
        chk({t.name, "/frame_start_errs"}, e_fs, 0);
        chk({t.name, "/sync_errs"}, e_sync, 0);
        chk({t.name, "/rgb_errs"}, e_rgb, 0);
        chk({t.name, "/hold_errs"}, e_hold, 0);
        chk({t.name, "/reads"}, c_reads, t.exp_reads);
        chk({t.name, "/frame_starts"}, c_fs, t.exp_fs);
        chk({t.name, "/hsync_low_ticks"}, c_hs, t.exp_hs);
        chk({t.name, "/vsync_low_ticks"}, c_vs, t.exp_vs);
        chk({t.name, "/final_addr"}, int'(fb_addr), t.exp_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t rs;
        vecs[0] = '{"rdy_early",   2, 360, 0,   9999, 64, 3, 72, 90, LAST_ADDR};
        vecs[1] = '{"rdy_mid_f0",  3, 360, 60,  9999, 64, 3, 72, 90, LAST_ADDR};
        vecs[2] = '{"rdy_mid_f1",  2, 360, 180, 9999, 32, 3, 72, 90, LAST_ADDR};
        vecs[3] = '{"rdy_drop",    2, 360, 0,   150,  64, 3, 72, 90, LAST_ADDR};
        vecs[4] = '{"rdy_short",   2, 360, 50,  100,  0,  3, 72, 90, 0};
        vecs[5] = '{"slow_pix",    5, 240, 0,   9999, 32, 2, 48, 60, LAST_ADDR};
        vecs[6] = '{"rand_gap",    0, 240, 0,   9999, 32, 2, 48, 60, LAST_ADDR};

        for (int i = 0; i < 7; i++) begin
            start_vec();
            if (i == 0) begin
                #1;
                chk("reset/hsync", int'(vga_hsync), 1);
                chk("reset/vsync", int'(vga_vsync), 1);
                chk("reset/rgb", int'({vga_r, vga_g, vga_b}), 0);
                chk("reset/fb_addr", int'(fb_addr), 0);
            end
            run_ticks(vecs[i].gap, vecs[i].ticks, vecs[i].rdy_on, vecs[i].rdy_off);
            finish_vec(vecs[i]);
            if (i == 0) chk("last_pixel_rgb", int'(last_px), 9'h1FF);
        end

        // Mid-frame reset at visible position (3,2) of the first running frame
        start_vec();
        run_ticks(2, FT + 2 * LT + 3, 0, 9999);
        chk("pre_reset/rgb", int'({vga_r, vga_g, vga_b}), int'(mem_word(20'(2 * HA + 1))));
        chk("pre_reset/addr_errs", e_rd, 0);
        @(negedge clk);
        rst_n = 1'b0;
        pix_en = 1'b1;
        #1;
        chk("in_reset/fb_re", int'(fb_re), 0);
        chk("in_reset/fb_addr", int'(fb_addr), 0);
        chk("in_reset/frame_start", int'(frame_start), 0);
        chk("in_reset/rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("in_reset/hsync", int'(vga_hsync), 1);
        chk("in_reset/vsync", int'(vga_vsync), 1);
        start_vec();
        run_ticks(2, 250, 0, 9999);
        rs = '{"after_reset", 2, 250, 0, 9999, 40, 2, 48, 60, 7};
        finish_vec(rs);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
